// File: rtl/bus_arbiter.sv
// Two-master shared-bus arbiter.
// Grants the bus to one master at a time, holds off the grant until the
// target slave reports ready, and reclaims the bus through a watchdog when
// a master keeps it too long. Every output is driven straight from a flop.
module bus_arbiter #(
    parameter int SLAVE_LEN   = 2,
    parameter int TIMEOUT_LEN = 8,
    parameter int TIMEOUT     = 200,
    parameter bit RR_MODE     = 1'b1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      req_m1,
    input  logic                      req_m2,
    input  logic                      release_m1,
    input  logic                      release_m2,
    input  logic [SLAVE_LEN-1:0]      slave_select_m1,
    input  logic [SLAVE_LEN-1:0]      slave_select_m2,
    input  logic [(1<<SLAVE_LEN)-1:0] slave_ready,
    output logic                      grant_m1,
    output logic                      grant_m2,
    output logic                      bus_busy,
    output logic                      master_sel,
    output logic [(1<<SLAVE_LEN)-1:0] slave_en,
    output logic                      timeout_err
);

    localparam int SLAVE_NUM = 1 << SLAVE_LEN;
    localparam logic [TIMEOUT_LEN-1:0] LAST_COUNT = TIMEOUT_LEN'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_SLAVE,
        ACTIVE,
        TURNAROUND
    } state_t;

    state_t state;
    state_t next_state;

    // owner / last_owner: 0 = master 1, 1 = master 2
    logic                   owner;
    logic                   owner_d;
    logic                   last_owner;
    logic                   last_owner_d;
    logic [SLAVE_LEN-1:0]   slave_latched;
    logic [SLAVE_LEN-1:0]   slave_latched_d;
    logic [TIMEOUT_LEN-1:0] count;
    logic [TIMEOUT_LEN-1:0] count_d;

    logic                   grant_m1_d;
    logic                   grant_m2_d;
    logic                   bus_busy_d;
    logic                   master_sel_d;
    logic [SLAVE_NUM-1:0]   slave_en_d;
    logic                   timeout_err_d;

    logic owner_req;
    logic owner_release;
    logic slave_ok;
    logic at_limit;
    logic winner;

    // Resolve the current owner's handshakes and who would win arbitration now
    always_comb begin
        owner_req     = owner ? req_m2 : req_m1;
        owner_release = owner ? release_m2 : release_m1;
        slave_ok      = slave_ready[slave_latched];
        at_limit      = (count == LAST_COUNT);
        if (req_m1 && req_m2) begin
            winner = RR_MODE ? ~last_owner : 1'b0;
        end else begin
            winner = req_m2;
        end
    end

    // State, latched transaction context and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            owner         <= 1'b0;
            last_owner    <= 1'b1;
            slave_latched <= '0;
            count         <= '0;
            grant_m1      <= 1'b0;
            grant_m2      <= 1'b0;
            bus_busy      <= 1'b0;
            master_sel    <= 1'b0;
            slave_en      <= '0;
            timeout_err   <= 1'b0;
        end else begin
            state         <= next_state;
            owner         <= owner_d;
            last_owner    <= last_owner_d;
            slave_latched <= slave_latched_d;
            count         <= count_d;
            grant_m1      <= grant_m1_d;
            grant_m2      <= grant_m2_d;
            bus_busy      <= bus_busy_d;
            master_sel    <= master_sel_d;
            slave_en      <= slave_en_d;
            timeout_err   <= timeout_err_d;
        end
    end

    // Next-state decision
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (req_m1 || req_m2) begin
                    next_state = WAIT_SLAVE;
                end
            end
            WAIT_SLAVE: begin
                if (!owner_req) begin
                    next_state = IDLE;
                end else if (slave_ok) begin
                    next_state = ACTIVE;
                end
            end
            ACTIVE: begin
                if (owner_release || !owner_req || at_limit) begin
                    next_state = TURNAROUND;
                end
            end
            TURNAROUND: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Values the outputs and transaction context take after the coming edge
    always_comb begin
        owner_d         = owner;
        last_owner_d    = last_owner;
        slave_latched_d = slave_latched;
        count_d         = count;
        grant_m1_d      = 1'b0;
        grant_m2_d      = 1'b0;
        bus_busy_d      = (next_state != IDLE);
        master_sel_d    = master_sel;
        slave_en_d      = '0;
        timeout_err_d   = 1'b0;
        case (state)
            IDLE: begin
                if (next_state == WAIT_SLAVE) begin
                    owner_d         = winner;
                    slave_latched_d = winner ? slave_select_m2 : slave_select_m1;
                    master_sel_d    = winner;
                end
            end
            WAIT_SLAVE: begin
                if (next_state == ACTIVE) begin
                    count_d                   = '0;
                    grant_m1_d                = ~owner;
                    grant_m2_d                = owner;
                    slave_en_d[slave_latched] = 1'b1;
                end
            end
            ACTIVE: begin
                if (next_state == ACTIVE) begin
                    count_d                   = count + 1'b1;
                    grant_m1_d                = ~owner;
                    grant_m2_d                = owner;
                    slave_en_d[slave_latched] = 1'b1;
                end else begin
                    last_owner_d  = owner;
                    timeout_err_d = at_limit && !owner_release;
                end
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter.
// Two instances run side by side: one round-robin with a 5-cycle watchdog,
// one fixed-priority with a 7-cycle watchdog. A transaction-level model
// predicts every registered output after each clock edge.
module tb_bus_arbiter;

    localparam int P_IDLE   = 0;
    localparam int P_WAIT   = 1;
    localparam int P_ACTIVE = 2;
    localparam int P_TURN   = 3;
    localparam int TO0      = 5;
    localparam int TO1      = 7;

    logic       clk;
    logic       reset;
    logic       req_m1;
    logic       req_m2;
    logic       release_m1;
    logic       release_m2;
    logic [1:0] rel1_v;
    logic [1:0] rel2_v;
    logic [1:0] sel_m1;
    logic [1:0] sel_m2;
    logic [3:0] slave_ready;

    logic       g1_0, g2_0, busy_0, msel_0, terr_0;
    logic       g1_1, g2_1, busy_1, msel_1, terr_1;
    logic [3:0] en_0, en_1;

    int checks;
    int failures;

    // model state per instance: phase, owner (1/2), last owner, target slave,
    // grant cycles elapsed, master_sel, timeout pulse
    int ph[2];
    int own[2];
    int last[2];
    int tgt[2];
    int held[2];
    int msel[2];
    bit terr[2];
    int to_of[2];
    bit rr_of[2];
    int auto_rel[2];

    bus_arbiter #(.SLAVE_LEN(2), .TIMEOUT_LEN(8), .TIMEOUT(TO0), .RR_MODE(1'b1)) dut_rr (
        .clk(clk), .reset(reset),
        .req_m1(req_m1), .req_m2(req_m2),
        .release_m1(rel1_v[0]), .release_m2(rel2_v[0]),
        .slave_select_m1(sel_m1), .slave_select_m2(sel_m2),
        .slave_ready(slave_ready),
        .grant_m1(g1_0), .grant_m2(g2_0), .bus_busy(busy_0),
        .master_sel(msel_0), .slave_en(en_0), .timeout_err(terr_0)
    );

    bus_arbiter #(.SLAVE_LEN(2), .TIMEOUT_LEN(8), .TIMEOUT(TO1), .RR_MODE(1'b0)) dut_fp (
        .clk(clk), .reset(reset),
        .req_m1(req_m1), .req_m2(req_m2),
        .release_m1(rel1_v[1]), .release_m2(rel2_v[1]),
        .slave_select_m1(sel_m1), .slave_select_m2(sel_m2),
        .slave_ready(slave_ready),
        .grant_m1(g1_1), .grant_m2(g2_1), .bus_busy(busy_1),
        .master_sel(msel_1), .slave_en(en_1), .timeout_err(terr_1)
    );

    // Free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(string tag, int m, logic [31:0] observed, logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s dut%0d t=%0t observed=%0h expected=%0h", tag, m, $time, observed, expected);
        end
    endtask

    // Advance the transaction model across one clock edge
    task automatic model_step(int m);
        bit oreq;
        bit orel;
        terr[m] = 1'b0;
        if (reset) begin
            ph[m]   = P_IDLE;
            last[m] = 2;
            held[m] = 0;
            msel[m] = 0;
        end else begin
            oreq = (own[m] == 1) ? req_m1 : req_m2;
            orel = (own[m] == 1) ? rel1_v[m] : rel2_v[m];
            case (ph[m])
                P_IDLE: begin
                    if (req_m1 || req_m2) begin
                        if (req_m1 && req_m2) own[m] = (rr_of[m] && last[m] == 1) ? 2 : 1;
                        else                  own[m] = req_m1 ? 1 : 2;
                        tgt[m]  = (own[m] == 1) ? int'(sel_m1) : int'(sel_m2);
                        msel[m] = own[m] - 1;
                        ph[m]   = P_WAIT;
                    end
                end
                P_WAIT: begin
                    if (!oreq) begin
                        ph[m] = P_IDLE;
                    end else if (slave_ready[tgt[m]]) begin
                        ph[m]   = P_ACTIVE;
                        held[m] = 1;
                    end
                end
                P_ACTIVE: begin
                    if (orel || !oreq || held[m] >= to_of[m]) begin
                        terr[m] = !orel && (held[m] >= to_of[m]);
                        last[m] = own[m];
                        ph[m]   = P_TURN;
                    end else begin
                        held[m]++;
                    end
                end
                default: ph[m] = P_IDLE;
            endcase
        end
    endtask

    task automatic compare_dut(int m);
        logic       g1, g2, bz, ms, te;
        logic [3:0] en;
        logic [3:0] exp_en;
        if (m == 0) begin
            g1 = g1_0; g2 = g2_0; bz = busy_0; ms = msel_0; te = terr_0; en = en_0;
        end else begin
            g1 = g1_1; g2 = g2_1; bz = busy_1; ms = msel_1; te = terr_1; en = en_1;
        end
        exp_en = '0;
        if (ph[m] == P_ACTIVE) exp_en[tgt[m]] = 1'b1;
        check_output("grant_m1", m, 32'(g1), 32'(ph[m] == P_ACTIVE && own[m] == 1));
        check_output("grant_m2", m, 32'(g2), 32'(ph[m] == P_ACTIVE && own[m] == 2));
        check_output("bus_busy", m, 32'(bz), 32'(ph[m] != P_IDLE));
        check_output("slave_en", m, 32'(en), 32'(exp_en));
        check_output("timeout_err", m, 32'(te), 32'(terr[m]));
        if (ph[m] != P_IDLE) check_output("master_sel", m, 32'(ms), 32'(msel[m]));
        check_output("grant_exclusive", m, 32'(g1 & g2), 32'(0));
        check_output("slave_en_onehot", m, 32'($countones(en) <= 1), 32'(1));
        check_output("slave_en_needs_grant", m, 32'(en != 4'b0 && !(g1 | g2)), 32'(0));
    endtask

    // One clock: drive per-instance releases, cross the edge, then compare
    task automatic apply_stimulus();
        for (int m = 0; m < 2; m++) begin
            rel1_v[m] = release_m1 | (auto_rel[m] != 0 && ph[m] == P_ACTIVE && own[m] == 1 && held[m] == auto_rel[m]);
            rel2_v[m] = release_m2 | (auto_rel[m] != 0 && ph[m] == P_ACTIVE && own[m] == 2 && held[m] == auto_rel[m]);
        end
        @(posedge clk);
        for (int m = 0; m < 2; m++) model_step(m);
        #1;
        for (int m = 0; m < 2; m++) compare_dut(m);
        @(negedge clk);
    endtask

    initial begin
        int   rr_order;
        int   order_q[$];
        int   fp_m2_grants;
        int   terr_seen;
        logic prev1, prev2;

        checks = 0;
        failures = 0;
        reset = 1'b1;
        req_m1 = 1'b0; req_m2 = 1'b0;
        release_m1 = 1'b0; release_m2 = 1'b0;
        rel1_v = '0; rel2_v = '0;
        sel_m1 = '0; sel_m2 = '0;
        slave_ready = '0;
        to_of = '{TO0, TO1};
        rr_of = '{1'b1, 1'b0};
        auto_rel = '{0, 0};
        own = '{1, 1};
        tgt = '{0, 0};
        @(negedge clk);

        $display("[TB] reset");
        apply_stimulus();
        apply_stimulus();
        check_output("reset_master_sel", 0, 32'(msel_0), 32'(0));
        check_output("reset_master_sel", 1, 32'(msel_1), 32'(0));
        reset = 1'b0;

        $display("[TB] single grant with release");
        sel_m1 = 2'd2; slave_ready = 4'b0100; req_m1 = 1'b1;
        apply_stimulus();
        apply_stimulus();
        check_output("grant_after_two_cycles", 0, 32'(g1_0), 32'(1));
        check_output("slave_en_latched", 0, 32'(en_0), 32'(4'b0100));
        apply_stimulus();
        release_m1 = 1'b1;
        apply_stimulus();
        release_m1 = 1'b0; req_m1 = 1'b0;
        repeat (3) apply_stimulus();

        $display("[TB] contention");
        reset = 1'b1;
        apply_stimulus();
        reset = 1'b0;
        req_m1 = 1'b1; req_m2 = 1'b1; slave_ready = 4'hF; sel_m1 = 2'd0; sel_m2 = 2'd3;
        auto_rel = '{3, 3};
        fp_m2_grants = 0;
        prev1 = 1'b0; prev2 = 1'b0;
        repeat (26) begin
            apply_stimulus();
            if (g1_0 && !prev1) order_q.push_back(1);
            if (g2_0 && !prev2) order_q.push_back(2);
            prev1 = g1_0; prev2 = g2_0;
            if (g2_1) fp_m2_grants++;
        end
        rr_order = 0;
        for (int i = 0; i < 3; i++) rr_order = rr_order * 4 + ((i < order_q.size()) ? order_q[i] : 0);
        check_output("rr_grant_order", 0, 32'(rr_order), 32'('h19));
        check_output("fp_no_m2_grant", 1, 32'(fp_m2_grants), 32'(0));
        req_m1 = 1'b0; req_m2 = 1'b0; auto_rel = '{0, 0};
        repeat (3) apply_stimulus();

        $display("[TB] slave not ready, then abort");
        sel_m2 = 2'd1; slave_ready = 4'b0000; req_m2 = 1'b1;
        repeat (11) apply_stimulus();
        slave_ready = 4'b0010;
        apply_stimulus();
        apply_stimulus();
        release_m2 = 1'b1;
        apply_stimulus();
        release_m2 = 1'b0; req_m2 = 1'b0;
        repeat (3) apply_stimulus();
        slave_ready = 4'b0000; req_m2 = 1'b1;
        repeat (4) apply_stimulus();
        req_m2 = 1'b0;
        repeat (3) apply_stimulus();

        $display("[TB] watchdog timeout");
        slave_ready = 4'hF; sel_m1 = 2'd3; sel_m2 = 2'd0;
        req_m1 = 1'b1; req_m2 = 1'b1;
        repeat (30) apply_stimulus();
        req_m1 = 1'b0; req_m2 = 1'b0;
        repeat (3) apply_stimulus();

        $display("[TB] release on the last allowed cycle");
        auto_rel = '{TO0, TO1};
        req_m1 = 1'b1;
        terr_seen = 0;
        repeat (20) begin
            apply_stimulus();
            if (terr_0 || terr_1) terr_seen++;
        end
        check_output("no_timeout_on_release", 0, 32'(terr_seen), 32'(0));
        req_m1 = 1'b0; auto_rel = '{0, 0};
        repeat (3) apply_stimulus();

        $display("[TB] reset during active grant");
        req_m1 = 1'b1;
        repeat (3) apply_stimulus();
        reset = 1'b1;
        apply_stimulus();
        reset = 1'b0;
        apply_stimulus();
        apply_stimulus();
        check_output("regrant_after_reset", 0, 32'(g1_0), 32'(1));
        apply_stimulus();
        req_m1 = 1'b0;
        repeat (3) apply_stimulus();

        $display("[TB] random traffic");
        for (int n = 0; n < 400; n++) begin
            reset = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 5) == 0) req_m1 = ~req_m1;
            if ($urandom_range(0, 5) == 0) req_m2 = ~req_m2;
            release_m1 = ($urandom_range(0, 6) == 0);
            release_m2 = ($urandom_range(0, 6) == 0);
            sel_m1 = 2'($urandom_range(0, 3));
            sel_m2 = 2'($urandom_range(0, 3));
            slave_ready = 4'($urandom_range(0, 15)) | 4'($urandom_range(0, 15));
            apply_stimulus();
        end
        reset = 1'b0; release_m1 = 1'b0; release_m2 = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
